// File: rtl/fwd_pkg.sv
// fwd_pkg: shared types and constants for the forwarding/hazard controller.
//
// Contents:
//   RD_W       - width of a register index held in the EX slot
//   REG_X0     - index of the hardwired-zero register
//   ex_slot_t  - {valid, rd, we, is_load} of the instruction currently in EX
//   SEL_*      - select encodings for the operand muxes
package fwd_pkg;

    localparam int unsigned RD_W = 5;

    localparam logic [RD_W-1:0] REG_X0 = '0;

    typedef struct packed {
        logic            valid;
        logic [RD_W-1:0] rd;
        logic            we;
        logic            is_load;
    } ex_slot_t;

    // A1_sel / B1_sel: regfile read vs. ALU result of the WB-stage producer.
    localparam logic SEL_REG = 1'b0;
    localparam logic SEL_ALU = 1'b1;
    // A2_sel: forwarded rs1 vs. PC.  B2_sel: forwarded rs2 vs. immediate.
    localparam logic SEL_PC  = 1'b1;
    localparam logic SEL_IMM = 1'b1;

endpackage

// File: rtl/fwd_perf_cnt.sv
// fwd_perf_cnt: one 32-bit event counter that sticks at all-ones instead of
// wrapping.
//
// Ports:
//   clk   in   core clock
//   rst   in   asynchronous active-high reset, clears the count
//   inc   in   count this cycle
//   count out  current count
module fwd_perf_cnt (
    input  logic        clk,
    input  logic        rst,
    input  logic        inc,
    output logic [31:0] count
);

    // NOTE: state is written with non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (inc && (count != 32'hFFFF_FFFF)) begin
            count <= count + 32'd1;
        end
    end

endmodule

// File: rtl/fwd_ctrl.sv
// fwd_ctrl: forwarding and hazard controller for the IF/ID/EX/WB pipeline.
//
// Tracks the instruction in EX, compares it with the register usage of the
// instruction in ID, and registers the operand-mux selects into EX. Load-use
// hazards stall for one cycle; a taken branch in EX flushes ID.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   id_valid                 ID holds a valid instruction
//   id_rs1/id_rs2/id_rd      register indices of the ID instruction
//   id_use_rs1/id_use_rs2    ID instruction reads rs1 / rs2
//   id_reg_we, id_is_load    ID instruction writes rd / is a load
//   id_opa_pc, id_opb_imm    ALU operand A is PC / operand B is immediate
//   ex_br_taken              branch or jump in EX resolved taken
//   A1_sel, B1_sel           registered rs1/rs2 forward selects
//   A2_sel, B2_sel           registered ALU operand A/B selects
//   stall, flush             combinational hazard controls
//   perf_stall_cnt, perf_fwd_cnt, perf_flush_cnt
//                            saturating event counters, present only when
//                            FWD_CTRL_PERF_EN is defined
//
// Build option: define FWD_CTRL_PERF_EN to add the performance counters.
// REG_AW must equal fwd_pkg::RD_W.
module fwd_ctrl
    import fwd_pkg::*;
#(
    parameter int REG_AW  = 5,
    parameter int NB_REGS = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic              id_reg_we,
    input  logic              id_is_load,
    input  logic              id_opa_pc,
    input  logic              id_opb_imm,
    input  logic              ex_br_taken,
    output logic              A1_sel,
    output logic              B1_sel,
    output logic              A2_sel,
    output logic              B2_sel,
    output logic              stall,
    output logic              flush
`ifdef FWD_CTRL_PERF_EN
    ,
    output logic [31:0]       perf_stall_cnt,
    output logic [31:0]       perf_fwd_cnt,
    output logic [31:0]       perf_flush_cnt
`endif
);

    ex_slot_t ex_q;

    logic producer_ok;
    logic hit_rs1;
    logic hit_rs2;
    logic load_hit;
    logic bubble;
    logic id_writes;

    // Only a valid EX instruction that really writes a non-zero register can
    // be a producer. The regfile is write-through, so WB needs no compare.
    assign producer_ok = ex_q.valid & ex_q.we & (ex_q.rd != REG_X0);

    assign hit_rs1 = id_valid & id_use_rs1 & producer_ok & (id_rs1 == ex_q.rd);
    assign hit_rs2 = id_valid & id_use_rs2 & producer_ok & (id_rs2 == ex_q.rd);

    // A load result only exists in WB, so a hit on it cannot be forwarded
    // from the ALU; one bubble lets write-through resolve it instead.
    assign load_hit = (hit_rs1 | hit_rs2) & ex_q.is_load;

    // A taken branch kills the ID instruction anyway, so its stall is moot.
    assign flush = ex_br_taken;
    assign stall = load_hit & ~ex_br_taken;

    assign bubble = flush | stall | ~id_valid;

    // Destinations beyond the implemented register file never produce.
    assign id_writes = id_reg_we & (32'(id_rd) < NB_REGS);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_q   <= '0;
            A1_sel <= SEL_REG;
            B1_sel <= SEL_REG;
            A2_sel <= 1'b0;
            B2_sel <= 1'b0;
        end else if (bubble) begin
            ex_q   <= '0;
            A1_sel <= SEL_REG;
            B1_sel <= SEL_REG;
            A2_sel <= 1'b0;
            B2_sel <= 1'b0;
        end else begin
            ex_q.valid   <= 1'b1;
            ex_q.rd      <= id_rd;
            ex_q.we      <= id_writes;
            ex_q.is_load <= id_is_load;
            A1_sel       <= hit_rs1 ? SEL_ALU : SEL_REG;
            B1_sel       <= hit_rs2 ? SEL_ALU : SEL_REG;
            A2_sel       <= id_opa_pc  ? SEL_PC  : 1'b0;
            B2_sel       <= id_opb_imm ? SEL_IMM : 1'b0;
        end
    end

`ifdef FWD_CTRL_PERF_EN
    fwd_perf_cnt u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (stall),
        .count (perf_stall_cnt)
    );

    // Counts EX cycles that actually consume a forwarded ALU result.
    fwd_perf_cnt u_fwd_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (A1_sel | B1_sel),
        .count (perf_fwd_cnt)
    );

    fwd_perf_cnt u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (flush),
        .count (perf_flush_cnt)
    );
`endif

endmodule

// File: tb/tb_fwd_ctrl.sv
// tb_fwd_ctrl: directed self-checking bench for fwd_ctrl.
//
// Each step drives one ID instruction at the falling edge, checks the
// combinational stall/flush, queues the expected EX-cycle selects, and
// compares them after the next rising edge. Perf counter checks are built
// only when FWD_CTRL_PERF_EN is defined.
module tb_fwd_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid;
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic [4:0] id_rd;
    logic       id_use_rs1;
    logic       id_use_rs2;
    logic       id_reg_we;
    logic       id_is_load;
    logic       id_opa_pc;
    logic       id_opb_imm;
    logic       ex_br_taken;
    logic       A1_sel;
    logic       B1_sel;
    logic       A2_sel;
    logic       B2_sel;
    logic       stall;
    logic       flush;
`ifdef FWD_CTRL_PERF_EN
    logic [31:0] perf_stall_cnt;
    logic [31:0] perf_fwd_cnt;
    logic [31:0] perf_flush_cnt;
`endif

    typedef struct packed {
        logic a1;
        logic b1;
        logic a2;
        logic b2;
    } sel_t;

    sel_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    fwd_ctrl #(
        .REG_AW  (5),
        .NB_REGS (32)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .id_valid    (id_valid),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_rd       (id_rd),
        .id_use_rs1  (id_use_rs1),
        .id_use_rs2  (id_use_rs2),
        .id_reg_we   (id_reg_we),
        .id_is_load  (id_is_load),
        .id_opa_pc   (id_opa_pc),
        .id_opb_imm  (id_opb_imm),
        .ex_br_taken (ex_br_taken),
        .A1_sel      (A1_sel),
        .B1_sel      (B1_sel),
        .A2_sel      (A2_sel),
        .B2_sel      (B2_sel),
        .stall       (stall),
        .flush       (flush)
`ifdef FWD_CTRL_PERF_EN
        ,
        .perf_stall_cnt (perf_stall_cnt),
        .perf_fwd_cnt   (perf_fwd_cnt),
        .perf_flush_cnt (perf_flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check1({tag, ".A1"}, A1_sel, 1'b0);
        check1({tag, ".B1"}, B1_sel, 1'b0);
        check1({tag, ".A2"}, A2_sel, 1'b0);
        check1({tag, ".B2"}, B2_sel, 1'b0);
        check1({tag, ".stall"}, stall, 1'b0);
        check1({tag, ".flush"}, flush, 1'b0);
    endtask

    // One ID cycle: drive, check stall/flush, queue selects, compare in EX.
    task automatic step(
        input string      tag,
        input logic       v,
        input logic [4:0] rs1,
        input logic [4:0] rs2,
        input logic [4:0] rd,
        input logic       u1,
        input logic       u2,
        input logic       we,
        input logic       ld,
        input logic       opa,
        input logic       opb,
        input logic       br,
        input logic       e_stall,
        input logic       e_flush,
        input sel_t       e_sel
    );
        sel_t got;
        @(negedge clk);
        id_valid    = v;
        id_rs1      = rs1;
        id_rs2      = rs2;
        id_rd       = rd;
        id_use_rs1  = u1;
        id_use_rs2  = u2;
        id_reg_we   = we;
        id_is_load  = ld;
        id_opa_pc   = opa;
        id_opb_imm  = opb;
        ex_br_taken = br;
        #1;
        check1({tag, ".stall"}, stall, e_stall);
        check1({tag, ".flush"}, flush, e_flush);
        exp_q.push_back(e_sel);
        @(posedge clk);
        #1;
        got = exp_q.pop_front();
        check1({tag, ".A1"}, A1_sel, got.a1);
        check1({tag, ".B1"}, B1_sel, got.b1);
        check1({tag, ".A2"}, A2_sel, got.a2);
        check1({tag, ".B2"}, B2_sel, got.b2);
    endtask

    initial begin
        rst         = 1'b1;
        id_valid    = 1'b0;
        id_rs1      = '0;
        id_rs2      = '0;
        id_rd       = '0;
        id_use_rs1  = 1'b0;
        id_use_rs2  = 1'b0;
        id_reg_we   = 1'b0;
        id_is_load  = 1'b0;
        id_opa_pc   = 1'b0;
        id_opb_imm  = 1'b0;
        ex_br_taken = 1'b0;
        #12;
        check_outputs_zero("reset");
`ifdef FWD_CTRL_PERF_EN
        check32("reset.perf_stall", perf_stall_cnt, 32'd0);
        check32("reset.perf_fwd",   perf_fwd_cnt,   32'd0);
        check32("reset.perf_flush", perf_flush_cnt, 32'd0);
`endif
        @(negedge clk);
        rst = 1'b0;

        //    tag         v  rs1 rs2 rd  u1 u2 we ld pc im br st fl  A1B1A2B2
        // ALU dependency, then a distance-2 consumer.
        step("alu_prod",  1, 1,  2,  5,  1, 1, 1, 0, 0, 0, 0, 0, 0, 4'b0000);
        step("alu_dep",   1, 5,  5,  6,  1, 1, 1, 0, 0, 0, 0, 0, 0, 4'b1100);
        step("dist2",     1, 5,  1,  7,  1, 1, 1, 0, 0, 0, 0, 0, 0, 4'b0000);
        // Load-use: lw x7 ; sw x7,0(x8) stalls once, then reads via regfile.
        step("lw_x7",     1, 1,  0,  7,  1, 0, 1, 1, 0, 1, 0, 0, 0, 4'b0001);
        step("sw_stall",  1, 8,  7,  0,  1, 1, 0, 0, 0, 1, 0, 1, 0, 4'b0000);
        step("sw_retry",  1, 8,  7,  0,  1, 1, 0, 0, 0, 1, 0, 0, 0, 4'b0001);
        // x0 never forwards.
        step("x0_prod",   1, 1,  2,  0,  1, 1, 1, 0, 0, 0, 0, 0, 0, 4'b0000);
        step("x0_use",    1, 0,  0,  9,  1, 1, 1, 0, 0, 0, 0, 0, 0, 4'b0000);
        // Taken branch while ID has a load-use hit: flush wins, EX empties.
        step("lw_x10",    1, 1,  0,  10, 1, 0, 1, 1, 0, 1, 0, 0, 0, 4'b0001);
        step("br_flush",  1, 10, 10, 11, 1, 1, 1, 0, 0, 0, 1, 0, 1, 4'b0000);
        step("post_fl",   1, 10, 0,  12, 1, 1, 1, 0, 0, 0, 0, 0, 0, 4'b0000);
        // PC/immediate operands alongside an rs1 forward.
        step("prod_x13",  1, 1,  2,  13, 1, 1, 1, 0, 0, 0, 0, 0, 0, 4'b0000);
        step("pc_imm",    1, 13, 0,  15, 1, 0, 1, 0, 1, 1, 0, 0, 0, 4'b1011);
        step("lw_x14",    1, 1,  0,  14, 1, 0, 1, 1, 0, 1, 0, 0, 0, 4'b0001);

        // Reset asserted during a load-use stall.
        @(negedge clk);
        id_valid   = 1'b1;
        id_rs1     = 5'd8;
        id_rs2     = 5'd14;
        id_rd      = 5'd0;
        id_use_rs1 = 1'b1;
        id_use_rs2 = 1'b1;
        id_reg_we  = 1'b0;
        id_is_load = 1'b0;
        id_opa_pc  = 1'b0;
        id_opb_imm = 1'b1;
        #1;
        check1("rst_mid.stall_before", stall, 1'b1);
        #1;
        rst = 1'b1;
        #1;
        check_outputs_zero("rst_mid");
`ifdef FWD_CTRL_PERF_EN
        check32("rst_mid.perf_stall", perf_stall_cnt, 32'd0);
        check32("rst_mid.perf_fwd",   perf_fwd_cnt,   32'd0);
        check32("rst_mid.perf_flush", perf_flush_cnt, 32'd0);
`endif
        @(negedge clk);
        rst = 1'b0;

        // id_valid=0 with a would-be load hit: no stall, EX bubble.
        step("lw_x16",    1, 1,  0,  16, 1, 0, 1, 1, 0, 1, 0, 0, 0, 4'b0001);
        step("invalid",   0, 16, 0,  17, 1, 0, 1, 0, 0, 0, 0, 0, 0, 4'b0000);
        step("after_inv", 1, 16, 0,  0,  1, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000);

`ifdef FWD_CTRL_PERF_EN
        // Three load-use pairs, then two forwarded operands.
        for (int i = 0; i < 3; i++) begin
            step("p_lw",    1, 1,  0,  20, 1, 0, 1, 1, 0, 0, 0, 0, 0, 4'b0000);
            step("p_stall", 1, 20, 0,  0,  1, 0, 0, 0, 0, 0, 0, 1, 0, 4'b0000);
            step("p_retry", 1, 20, 0,  0,  1, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000);
        end
        step("p_x21",     1, 1,  0,  21, 1, 0, 1, 0, 0, 0, 0, 0, 0, 4'b0000);
        step("p_fwd1",    1, 21, 0,  22, 1, 0, 1, 0, 0, 0, 0, 0, 0, 4'b1000);
        step("p_fwd2",    1, 22, 0,  23, 1, 0, 1, 0, 0, 0, 0, 0, 0, 4'b1000);
        step("p_idle",    0, 0,  0,  0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000);
        check32("perf.stall", perf_stall_cnt, 32'd3);
        check32("perf.fwd",   perf_fwd_cnt,   32'd2);
        check32("perf.flush", perf_flush_cnt, 32'd0);
        #1;
        rst = 1'b1;
        #1;
        check32("perf_rst.stall", perf_stall_cnt, 32'd0);
        check32("perf_rst.fwd",   perf_fwd_cnt,   32'd0);
        check32("perf_rst.flush", perf_flush_cnt, 32'd0);
        @(negedge clk);
        rst = 1'b0;
`endif

        // Final reset leaves every output at 0.
        @(negedge clk);
        rst = 1'b1;
        id_valid = 1'b0;
        #1;
        check_outputs_zero("final_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
